ball_mover: RTL and testbench

- Upstream neighbour of the ball bitmap stage. Holds one ball's position and velocity and updates them once per video frame: gravity, floor bounce, wall bounce, and a pop on rope hit.
- Per pixel, it produces the offset-in-rectangle, inside-rectangle and visible signals that the bitmap stage uses to fetch colour.
- One instance per ball; the top level instantiates several.

---
 rtl/ball_pkg.sv | 19 +
 rtl/square_window.sv | 32 +++
 rtl/ball_mover.sv | 166 ++++++++++++++++
 tb/tb_ball_mover.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and constants for the moving screen objects (ball, rope, player).
package ball_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    POPPING,
    DEAD
  } state_t;

  localparam int FIXED_POINT_SHIFT = 6;
  localparam int SCREEN_WIDTH      = 640;
  localparam int SCREEN_HEIGHT     = 480;

  // Positions carry 6 fractional bits; speeds are in 1/64 pixel per frame.
  typedef logic signed [16:0] position_t;
  typedef logic signed [11:0] speed_t;

endpackage

// File: rtl/square_window.sv
// Combinational rectangle hit test: raw pixel offsets from the top-left corner
// plus an inside flag. Shared by the ball, rope and player objects.
module square_window #(
  parameter int WIDTH  = 26,
  parameter int HEIGHT = 26
) (
  input  logic [10:0] i_pixel_x,
  input  logic [10:0] i_pixel_y,
  input  logic [10:0] i_top_left_x,
  input  logic [10:0] i_top_left_y,
  output logic [10:0] o_offset_x,
  output logic [10:0] o_offset_y,
  output logic        o_inside
);

  logic [11:0] w_right;
  logic [11:0] w_bottom;
  logic        w_in_x;
  logic        w_in_y;

  // One extra bit so a rectangle near column 2047 does not wrap around.
  assign w_right  = {1'b0, i_top_left_x} + 12'(WIDTH);
  assign w_bottom = {1'b0, i_top_left_y} + 12'(HEIGHT);

  assign w_in_x = (i_pixel_x >= i_top_left_x) && ({1'b0, i_pixel_x} < w_right);
  assign w_in_y = (i_pixel_y >= i_top_left_y) && ({1'b0, i_pixel_y} < w_bottom);

  assign o_inside   = w_in_x && w_in_y;
  assign o_offset_x = i_pixel_x - i_top_left_x;
  assign o_offset_y = i_pixel_y - i_top_left_y;

endmodule

// File: rtl/ball_mover.sv
// One ball: per-frame physics (gravity, floor/wall bounce, rope pop) and per-pixel window outputs.
// Build option BALL_POP_BLINK_EN: blink for POP_FRAMES frames before vanishing; otherwise a one-frame pop.
//
// state   | meaning
// IDLE    | waiting for launch, not drawn
// MOVING  | physics active, drawn, rope hits latched
// POPPING | pop animation after a rope hit
// DEAD    | gone until reset
module ball_mover
  import ball_pkg::*;
#(
  parameter int INIT_X         = 100,
  parameter int INIT_Y         = 50,
  parameter int INIT_SPEED_X   = 64,
  parameter int BOUNCE_SPEED_Y = -320,
  parameter int GRAVITY        = 8,
  parameter int MAX_FALL       = 512,
  parameter int OBJECT_WIDTH   = 26,
  parameter int OBJECT_HEIGHT  = 26,
  parameter int FLOOR_Y        = 440,
  parameter int RIGHT_WALL     = SCREEN_WIDTH - 1,
  parameter int POP_FRAMES     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        launch,
  input  logic        hitRope,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        insideRectangle,
  output logic        visible,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        popped
);

  localparam int CNT_W = (POP_FRAMES < 4) ? 2 : $clog2(POP_FRAMES + 1);
`ifdef BALL_POP_BLINK_EN
  localparam int POP_LAST = POP_FRAMES - 1;
`else
  localparam int POP_LAST = 0;
`endif

  state_t           r_state;
  position_t        r_pos_x;
  position_t        r_pos_y;
  speed_t           r_spd_x;
  speed_t           r_spd_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hit;
  logic             r_visible;
  logic             r_popped;

  logic [CNT_W-1:0] w_cnt_inc;
  int               w_spd_y_grav;
  int               w_pos_x_new;
  int               w_pos_y_new;
  position_t        w_pos_x_nxt;
  position_t        w_pos_y_nxt;
  speed_t           w_spd_x_nxt;
  speed_t           w_spd_y_nxt;

  // Bounce tests look at the speed sign so a clamped ball always leaves the wall.
  always_comb begin
    w_spd_y_grav = int'(r_spd_y) + GRAVITY;
    if (w_spd_y_grav > MAX_FALL) w_spd_y_grav = MAX_FALL;
    w_pos_x_new = int'(r_pos_x) + int'(r_spd_x);
    w_pos_y_new = int'(r_pos_y) + w_spd_y_grav;
    w_pos_x_nxt = position_t'(w_pos_x_new);
    w_pos_y_nxt = position_t'(w_pos_y_new);
    w_spd_x_nxt = r_spd_x;
    w_spd_y_nxt = speed_t'(w_spd_y_grav);
    if ((int'(r_spd_x) > 0) &&
        ((w_pos_x_new >>> FIXED_POINT_SHIFT) + OBJECT_WIDTH >= RIGHT_WALL)) begin
      w_pos_x_nxt = position_t'((RIGHT_WALL - OBJECT_WIDTH) <<< FIXED_POINT_SHIFT);
      w_spd_x_nxt = -r_spd_x;
    end else if ((int'(r_spd_x) < 0) && (w_pos_x_new <= 0)) begin
      w_pos_x_nxt = '0;
      w_spd_x_nxt = -r_spd_x;
    end
    if ((w_spd_y_grav > 0) &&
        ((w_pos_y_new >>> FIXED_POINT_SHIFT) + OBJECT_HEIGHT >= FLOOR_Y)) begin
      w_pos_y_nxt = position_t'((FLOOR_Y - OBJECT_HEIGHT) <<< FIXED_POINT_SHIFT);
      w_spd_y_nxt = speed_t'(BOUNCE_SPEED_Y);
    end
  end

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pos_x   <= position_t'(INIT_X <<< FIXED_POINT_SHIFT);
      r_pos_y   <= position_t'(INIT_Y <<< FIXED_POINT_SHIFT);
      r_spd_x   <= speed_t'(INIT_SPEED_X);
      r_spd_y   <= '0;
      r_cnt     <= '0;
      r_hit     <= 1'b0;
      r_visible <= 1'b0;
      r_popped  <= 1'b0;
    end else begin
      r_popped <= 1'b0;
      case (r_state)
        IDLE: begin
          if (launch) begin
            r_state   <= MOVING;
            r_visible <= 1'b1;
          end
        end
        MOVING: begin
          r_hit <= r_hit | hitRope;
          if (startOfFrame) begin
            r_pos_x <= w_pos_x_nxt;
            r_pos_y <= w_pos_y_nxt;
            r_spd_x <= w_spd_x_nxt;
            r_spd_y <= w_spd_y_nxt;
            r_hit   <= 1'b0;
            if (r_hit || hitRope) begin
              r_state   <= POPPING;
              r_cnt     <= '0;
              r_visible <= 1'b0;
            end
          end
        end
        POPPING: begin
          if (startOfFrame) begin
            if (r_cnt == CNT_W'(POP_LAST)) begin
              r_state   <= DEAD;
              r_popped  <= 1'b1;
              r_visible <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
`ifdef BALL_POP_BLINK_EN
              r_visible <= w_cnt_inc[1];
`endif
            end
          end
        end
        DEAD: r_visible <= 1'b0;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign visible  = r_visible;
  assign popped   = r_popped;
  assign topLeftX = r_pos_x[FIXED_POINT_SHIFT +: 11];
  assign topLeftY = r_pos_y[FIXED_POINT_SHIFT +: 11];

  square_window #(
    .WIDTH (OBJECT_WIDTH),
    .HEIGHT(OBJECT_HEIGHT)
  ) u_window (
    .i_pixel_x   (pixelX),
    .i_pixel_y   (pixelY),
    .i_top_left_x(topLeftX),
    .i_top_left_y(topLeftY),
    .o_offset_x  (offsetX),
    .o_offset_y  (offsetY),
    .o_inside    (insideRectangle)
  );

endmodule

// File: tb/tb_ball_mover.sv
// Self-checking bench for ball_mover against a frame-level behavioural model.
module tb_ball_mover;

  localparam int FL = 4;
  localparam int S_IDLE = 0;
  localparam int S_MOVE = 1;
  localparam int S_POP  = 2;
  localparam int S_DEAD = 3;
`ifdef BALL_POP_BLINK_EN
  localparam int POP_LEN = 16;
  localparam bit BLINK   = 1'b1;
`else
  localparam int POP_LEN = 1;
  localparam bit BLINK   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        launch = 1'b0;
  logic        hitRope = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic [10:0] offsetX, offsetY, topLeftX, topLeftY;
  logic        insideRectangle, visible, popped;

  int n_tests = 0;
  int n_fail  = 0;

  int m_px, m_py, m_sx, m_sy, m_state, m_age;
  bit m_hit;

  ball_mover dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .launch         (launch),
    .hitRope        (hitRope),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .insideRectangle(insideRectangle),
    .visible        (visible),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .popped         (popped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_px = 100 * 64; m_py = 50 * 64; m_sx = 64; m_sy = 0;
    m_state = S_IDLE; m_age = 0; m_hit = 1'b0;
  endfunction

  function automatic bit model_sof(input bit h);
    bit pop_now = 1'b0;
    if (m_state == S_MOVE) begin
      m_sy = m_sy + 8;
      if (m_sy > 512) m_sy = 512;
      m_px = m_px + m_sx;
      m_py = m_py + m_sy;
      if (m_sx > 0 && (m_px >>> 6) + 26 >= 639) begin m_px = 613 * 64; m_sx = -m_sx; end
      else if (m_sx < 0 && m_px <= 0) begin m_px = 0; m_sx = -m_sx; end
      if (m_sy > 0 && (m_py >>> 6) + 26 >= 440) begin m_py = 414 * 64; m_sy = -320; end
      if (m_hit || h) begin m_state = S_POP; m_age = 0; end
      m_hit = 1'b0;
    end else if (m_state == S_POP) begin
      m_age = m_age + 1;
      if (m_age == POP_LEN) begin m_state = S_DEAD; pop_now = 1'b1; end
    end
    return pop_now;
  endfunction

  function automatic logic [10:0] exp_tlx(); return 11'(m_px >>> 6); endfunction
  function automatic logic [10:0] exp_tly(); return 11'(m_py >>> 6); endfunction
  function automatic logic exp_vis();
    if (m_state == S_MOVE) return 1'b1;
    if (m_state == S_POP && BLINK) return ((m_age / 2) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; startOfFrame = 1'b0; launch = 1'b0; hitRope = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_launch();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    if (m_state == S_IDLE) m_state = S_MOVE;
  endtask

  task automatic do_frame(input int hit_cycle, output int pop_cycle, output bit exp_pop);
    pop_cycle = -1;
    exp_pop = 1'b0;
    for (int c = 0; c < FL; c++) begin
      startOfFrame = (c == 0);
      hitRope = (c == hit_cycle);
      tick();
      if (c == 0) exp_pop = model_sof(hitRope);
      else if (hitRope && m_state == S_MOVE) m_hit = 1'b1;
      if (popped) pop_cycle = (pop_cycle < 0) ? c : 99;
    end
    startOfFrame = 1'b0;
    hitRope = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 4;
    if (visible !== 1'b0) begin n_fail++; $display("FAIL reset_visible: got %b want 0", visible); end
    if (popped !== 1'b0) begin n_fail++; $display("FAIL reset_popped: got %b want 0", popped); end
    if (topLeftX !== exp_tlx()) begin n_fail++; $display("FAIL reset_x: got %0d want %0d", topLeftX, exp_tlx()); end
    if (topLeftY !== exp_tly()) begin n_fail++; $display("FAIL reset_y: got %0d want %0d", topLeftY, exp_tly()); end
  endtask

  task automatic test_pixel_window();
    int vec [5][3] = '{'{125, 75, 1}, '{126, 75, 0}, '{100, 50, 1}, '{99, 50, 0}, '{125, 76, 0}};
    for (int i = 0; i < 35; i++) begin
      int px, py, tx, ty;
      logic ei;
      tx = int'(exp_tlx()); ty = int'(exp_tly());
      if (i < 5) begin px = vec[i][0]; py = vec[i][1]; end
      else begin px = tx - 4 + int'($urandom_range(0, 34)); py = ty - 4 + int'($urandom_range(0, 34)); end
      pixelX = 11'(px); pixelY = 11'(py);
      #1;
      ei = (px >= tx) && (px < tx + 26) && (py >= ty) && (py < ty + 26);
      n_tests += 3;
      if (i < 5 && ei !== vec[i][2][0]) $display("note: table entry %0d disagrees with window rule", i);
      if (insideRectangle !== ei) begin n_fail++; $display("FAIL window_inside(%0d,%0d): got %b want %b", px, py, insideRectangle, ei); end
      if (offsetX !== 11'(px - tx)) begin n_fail++; $display("FAIL window_offx: got %0d want %0d", offsetX, 11'(px - tx)); end
      if (offsetY !== 11'(py - ty)) begin n_fail++; $display("FAIL window_offy: got %0d want %0d", offsetY, 11'(py - ty)); end
    end
  endtask

  task automatic test_idle_ignore();
    int pc; bit ep;
    for (int f = 0; f < 3; f++) begin
      do_frame(1 + f % 3, pc, ep);
      n_tests += 3;
      if (topLeftX !== 11'd100 || topLeftY !== 11'd50) begin
        n_fail++; $display("FAIL idle_pos: got (%0d,%0d) want (100,50)", topLeftX, topLeftY);
      end
      if (visible !== 1'b0) begin n_fail++; $display("FAIL idle_visible: got %b want 0", visible); end
      if (pc != -1) begin n_fail++; $display("FAIL idle_popped: popped at cycle %0d want none", pc); end
    end
  endtask

  task automatic test_launch();
    int pc; bit ep;
    do_launch();
    n_tests += 1;
    if (visible !== 1'b1) begin n_fail++; $display("FAIL launch_visible: got %b want 1", visible); end
    do_frame(-1, pc, ep);
    n_tests += 3;
    if (topLeftX !== 11'd101) begin n_fail++; $display("FAIL first_frame_x: got %0d want 101", topLeftX); end
    if (topLeftY !== 11'd50) begin n_fail++; $display("FAIL first_frame_y: got %0d want 50", topLeftY); end
    if (visible !== 1'b1) begin n_fail++; $display("FAIL first_frame_vis: got %b want 1", visible); end
  endtask

  task automatic test_flight();
    int pc; bit ep;
    int max_y = 0;
    int floor_f = -1;
    int wall_f = -1;
    bit saw_left = 1'b0;
    for (int f = 0; f < 1300; f++) begin
      if ($urandom_range(0, 9) == 0) do_launch();
      do_frame(-1, pc, ep);
      n_tests += 4;
      if (topLeftX !== exp_tlx()) begin n_fail++; $display("FAIL flight_x f%0d: got %0d want %0d", f, topLeftX, exp_tlx()); end
      if (topLeftY !== exp_tly()) begin n_fail++; $display("FAIL flight_y f%0d: got %0d want %0d", f, topLeftY, exp_tly()); end
      if (visible !== 1'b1) begin n_fail++; $display("FAIL flight_vis f%0d: got %b want 1", f, visible); end
      if (pc != -1) begin n_fail++; $display("FAIL flight_popped f%0d: cycle %0d want none", f, pc); end
      if (int'(topLeftY) > max_y) max_y = int'(topLeftY);
      if (floor_f >= 0 && f == floor_f + 1) begin
        n_tests++;
        if (topLeftY !== 11'd409) begin n_fail++; $display("FAIL floor_rebound: got %0d want 409", topLeftY); end
      end
      if (wall_f >= 0 && f == wall_f + 1) begin
        n_tests++;
        if (topLeftX !== 11'd612) begin n_fail++; $display("FAIL wall_rebound: got %0d want 612", topLeftX); end
      end
      if (floor_f < 0 && topLeftY == 11'd414) floor_f = f;
      if (wall_f < 0 && topLeftX == 11'd613) wall_f = f;
      if (wall_f >= 0 && topLeftX == 11'd0) saw_left = 1'b1;
    end
    n_tests += 4;
    if (max_y > 414) begin n_fail++; $display("FAIL floor_limit: max row %0d want <= 414", max_y); end
    if (floor_f < 0) begin n_fail++; $display("FAIL floor_reached: got never want row 414"); end
    if (wall_f < 0) begin n_fail++; $display("FAIL right_wall_reached: got never want column 613"); end
    if (!saw_left) begin n_fail++; $display("FAIL left_wall_reached: got never want column 0"); end
  endtask

  task automatic test_pop();
    int pc; bit ep;
    int frames_to_pop = -1;
    int npops = 0;
    do_frame(int'($urandom_range(1, FL - 1)), pc, ep);
    n_tests += 2;
    if (visible !== 1'b1) begin n_fail++; $display("FAIL pop_hit_frame_vis: got %b want 1", visible); end
    if (pc != -1) begin n_fail++; $display("FAIL pop_hit_frame_popped: cycle %0d want none", pc); end
    do_frame(-1, pc, ep);
    n_tests++;
    if (visible !== exp_vis()) begin n_fail++; $display("FAIL pop_entry_vis: got %b want %b", visible, exp_vis()); end
    for (int f = 1; f <= POP_LEN + 3; f++) begin
      do_frame(($urandom_range(0, 1) == 1) ? 2 : -1, pc, ep);
      n_tests += 2;
      if (visible !== exp_vis()) begin n_fail++; $display("FAIL pop_vis f%0d: got %b want %b", f, visible, exp_vis()); end
      if (pc != (ep ? 0 : -1)) begin n_fail++; $display("FAIL pop_pulse f%0d: cycle %0d want %0d", f, pc, ep ? 0 : -1); end
      if (pc >= 0) npops++;
      if (pc == 0 && frames_to_pop < 0) frames_to_pop = f;
    end
    n_tests += 2;
    if (frames_to_pop != POP_LEN) begin n_fail++; $display("FAIL pop_length: got %0d want %0d", frames_to_pop, POP_LEN); end
    if (npops != 1) begin n_fail++; $display("FAIL pop_count: got %0d want 1", npops); end
    do_launch();
    do_frame(1, pc, ep);
    n_tests += 2;
    if (visible !== 1'b0) begin n_fail++; $display("FAIL dead_vis: got %b want 0", visible); end
    if (pc != -1) begin n_fail++; $display("FAIL dead_popped: cycle %0d want none", pc); end
  endtask

  task automatic test_reset_mid_pop();
    int pc; bit ep;
    bit any_pop = 1'b0;
    do_reset();
    do_launch();
    for (int f = 0; f < 3; f++) begin
      do_frame(-1, pc, ep);
      if (pc >= 0) any_pop = 1'b1;
    end
    do_frame(2, pc, ep);
    if (pc >= 0) any_pop = 1'b1;
    do_frame(-1, pc, ep);
    if (pc >= 0) any_pop = 1'b1;
    for (int f = 0; f < POP_LEN - 1 && f < 4; f++) begin
      do_frame(-1, pc, ep);
      if (pc >= 0) any_pop = 1'b1;
    end
    tick();
    if (popped) any_pop = 1'b1;
    do_reset();
    if (popped) any_pop = 1'b1;
    n_tests += 4;
    if (any_pop) begin n_fail++; $display("FAIL midpop_popped: got asserted want never"); end
    if (visible !== 1'b0) begin n_fail++; $display("FAIL midpop_vis: got %b want 0", visible); end
    if (topLeftX !== 11'd100 || topLeftY !== 11'd50) begin
      n_fail++; $display("FAIL midpop_pos: got (%0d,%0d) want (100,50)", topLeftX, topLeftY);
    end
    do_frame(-1, pc, ep);
    if (visible !== 1'b0) begin n_fail++; $display("FAIL midpop_idle_vis: got %b want 0", visible); end
    do_launch();
    do_frame(-1, pc, ep);
    n_tests += 2;
    if (topLeftX !== 11'd101) begin n_fail++; $display("FAIL relaunch_x: got %0d want 101", topLeftX); end
    if (visible !== 1'b1) begin n_fail++; $display("FAIL relaunch_vis: got %b want 1", visible); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pixel_window();
    test_idle_ignore();
    test_launch();
    test_flight();
    test_pop();
    test_reset_mid_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
